sprite_linebuf_pp: RTL and testbench

Parametrised ping-pong sprite line buffer for the object layer. One bank is filled by the sprite renderer while the other is scanned out to the colour mixer. The scanned bank is cleared pixel by pixel behind the read. Generalises the fixed 8-bit double buffer with:
- configurable line length, pixel width and transparency field;
- a stream handshake on the write side;
- an optional first-wins priority mode.

---
 rtl/sprite_linebuf_pp_pkg.sv | 14 +
 rtl/sprite_linebuf_pp_bank.sv | 30 +++
 rtl/sprite_linebuf_pp.sv | 188 ++++++++++++++++++
 tb/tb_sprite_linebuf_pp.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sprite_linebuf_pp_pkg.sv
// Shared types and helpers for the ping-pong sprite line buffer.
package linebuf_pkg;

  localparam int X_W_DFLT = 8;
  localparam int LINE_LEN = 2**X_W_DFLT;

  typedef enum logic [1:0] {W_IDLE, W_RD, W_CK} wstate_t;

  // Pen bits below trans_w all zero means the pixel is see-through.
  function automatic logic is_trans(input logic [31:0] pix, input int trans_w);
    return (pix & ((32'h1 << trans_w) - 32'h1)) == 32'h0;
  endfunction

endpackage

// File: rtl/sprite_linebuf_pp_bank.sv
// One line bank: dual-port RAM, both ports read/write with a 1-clock registered read.
module lb_bank #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] a_rdata_q, b_rdata_q;

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
    a_rdata_q <= mem[a_addr];
    b_rdata_q <= mem[b_addr];
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/sprite_linebuf_pp.sv
// Ping-pong sprite line buffer: renderer fills one bank while the other is scanned and cleared.
// SPRITE_LINEBUF_PRIO_EN builds the first-wins read-check-write path; default is last-wins.
module sprite_linebuf_pp
  import linebuf_pkg::*;
#(
  parameter int X_W      = X_W_DFLT,
  parameter int PIX_W    = 8,
  parameter int TRANS_W  = 3,
  parameter int X_OFFSET = 8'hFF,
  parameter int RD_START = 0
) (
  input  logic             clk48m,
  input  logic             nRESET,
  input  logic             pix_ce,
  input  logic             line_start,
  input  logic             flip,
  input  logic             wr_load,
  input  logic [X_W-1:0]   wr_x,
  input  logic             wr_valid,
  input  logic [PIX_W-1:0] wr_pix,
  output logic             wr_ready,
  output logic [PIX_W-1:0] rd_pix,
  output logic             bank_sel
);

  logic [1:0]            a_we, b_we;
  logic [1:0][X_W-1:0]   a_addr, b_addr;
  logic [1:0][PIX_W-1:0] a_wdata, b_wdata, a_rdata, b_rdata;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    lb_bank #(.AW(X_W), .DW(PIX_W)) u_bank (
      .clk(clk48m),
      .a_we(a_we[g]), .a_addr(a_addr[g]), .a_wdata(a_wdata[g]), .a_rdata(a_rdata[g]),
      .b_we(b_we[g]), .b_addr(b_addr[g]), .b_wdata(b_wdata[g]), .b_rdata(b_rdata[g])
    );
  end

  logic             bank_sel_q, bank_sel_d, flip_l_q, flip_l_d;
  logic             line_seen_q, line_seen_d, rd_armed_q, rd_armed_d;
  logic             clr_q, clr_d, clr_bank_q, clr_bank_d;
  logic             rd_vld_q, rd_vld_d, rd_bank_q, rd_bank_d;
  logic [X_W-1:0]   rd_x_q, rd_x_d, clr_addr_q, clr_addr_d, wx_q, wx_d;
  logic [PIX_W-1:0] rd_pix_q, rd_pix_d;
  logic             rd_bank_now, rd_flip_now;
  logic [X_W-1:0]   rd_x_now, rd_addr;

  // A line_start coinciding with pix_ce reads RD_START from the bank being swapped in.
  always_comb begin
    rd_bank_now = line_start ? bank_sel_q : ~bank_sel_q;
    rd_flip_now = line_start ? flip : flip_l_q;
    rd_x_now    = line_start ? X_W'(RD_START) : rd_x_q;
    rd_addr     = rd_x_now ^ {X_W{rd_flip_now}};
    bank_sel_d  = line_start ? ~bank_sel_q : bank_sel_q;
    flip_l_d    = rd_flip_now;
    rd_x_d      = pix_ce ? rd_x_now + X_W'(1) : rd_x_now;
    clr_d       = pix_ce;
    clr_bank_d  = rd_bank_now;
    clr_addr_d  = rd_addr;
    rd_vld_d    = pix_ce;
    rd_bank_d   = rd_bank_now;
    line_seen_d = line_seen_q | line_start;
    rd_armed_d  = rd_armed_q | (line_start & line_seen_q);
    rd_pix_d    = rd_pix_q;
    if (rd_vld_q) rd_pix_d = rd_armed_q ? b_rdata[rd_bank_q] : '0;
    for (int i = 0; i < 2; i++) begin
      b_we[i]    = clr_q && (clr_bank_q == 1'(i));
      b_addr[i]  = b_we[i] ? clr_addr_q : rd_addr;
      b_wdata[i] = '0;
    end
  end

  logic [X_W-1:0]   ld_x, wdst, wa_addr;
  logic             wa_bank, wa_we, accept;
  logic [PIX_W-1:0] wa_data;

  assign ld_x   = wr_x + X_W'(X_OFFSET);
  assign wdst   = wr_load ? ld_x : wx_q;
  assign accept = wr_valid & wr_ready;

  always_comb begin
    wx_d = wr_load ? ld_x : wx_q;
    if (accept) wx_d = wdst + X_W'(1);
  end

`ifdef SPRITE_LINEBUF_PRIO_EN
  wstate_t          st_q, st_d;
  logic [X_W-1:0]   waddr_q, waddr_d;
  logic [PIX_W-1:0] wpix_q, wpix_d;
  logic             wbank_q, wbank_d;

  assign wr_ready = (st_q == W_IDLE);

  // Destination is read on accept; the write lands in the bank latched then, even across a swap.
  always_comb begin
    st_d    = st_q;
    waddr_d = waddr_q;
    wpix_d  = wpix_q;
    wbank_d = wbank_q;
    wa_bank = bank_sel_q;
    wa_addr = wdst;
    wa_we   = 1'b0;
    wa_data = wpix_q;
    case (st_q)
      W_IDLE: if (accept) begin
        st_d    = W_RD;
        waddr_d = wdst;
        wpix_d  = wr_pix;
        wbank_d = bank_sel_q;
      end
      W_RD: begin
        wa_bank = wbank_q;
        wa_addr = waddr_q;
        wa_we   = is_trans(32'(a_rdata[wbank_q]), TRANS_W) && !is_trans(32'(wpix_q), TRANS_W);
        st_d    = W_CK;
      end
      default: st_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk48m or negedge nRESET) begin
    if (!nRESET) begin
      st_q    <= W_IDLE;
      waddr_q <= '0;
      wpix_q  <= '0;
      wbank_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      waddr_q <= waddr_d;
      wpix_q  <= wpix_d;
      wbank_q <= wbank_d;
    end
  end
`else
  logic unused_rdata;

  assign wr_ready     = 1'b1;
  assign unused_rdata = ^a_rdata;

  always_comb begin
    wa_bank = bank_sel_q;
    wa_addr = wdst;
    wa_we   = accept && !is_trans(32'(wr_pix), TRANS_W);
    wa_data = wr_pix;
  end
`endif

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      a_we[i]    = wa_we && (wa_bank == 1'(i));
      a_addr[i]  = wa_addr;
      a_wdata[i] = wa_data;
    end
  end

  always_ff @(posedge clk48m or negedge nRESET) begin
    if (!nRESET) begin
      bank_sel_q  <= 1'b0;
      flip_l_q    <= 1'b0;
      line_seen_q <= 1'b0;
      rd_armed_q  <= 1'b0;
      clr_q       <= 1'b0;
      clr_bank_q  <= 1'b0;
      clr_addr_q  <= '0;
      rd_vld_q    <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_x_q      <= '0;
      wx_q        <= '0;
      rd_pix_q    <= '0;
    end else begin
      bank_sel_q  <= bank_sel_d;
      flip_l_q    <= flip_l_d;
      line_seen_q <= line_seen_d;
      rd_armed_q  <= rd_armed_d;
      clr_q       <= clr_d;
      clr_bank_q  <= clr_bank_d;
      clr_addr_q  <= clr_addr_d;
      rd_vld_q    <= rd_vld_d;
      rd_bank_q   <= rd_bank_d;
      rd_x_q      <= rd_x_d;
      wx_q        <= wx_d;
      rd_pix_q    <= rd_pix_d;
    end
  end

  assign rd_pix   = rd_pix_q;
  assign bank_sel = bank_sel_q;

endmodule

// File: tb/tb_sprite_linebuf_pp.sv
// Directed bench for sprite_linebuf_pp; priority section is built when SPRITE_LINEBUF_PRIO_EN is defined.
module tb_sprite_linebuf_pp;
  import linebuf_pkg::*;

  logic       clk48m = 1'b0;
  logic       nRESET, pix_ce, line_start, flip, wr_load, wr_valid;
  logic [7:0] wr_x, wr_pix, rd_pix;
  logic       wr_ready, bank_sel;

  int total = 0;
  int bad   = 0;

  logic [7:0] line_d [LINE_LEN];
  logic [7:0] mid_d  [LINE_LEN];
  logic [7:0] exp_l  [LINE_LEN];

  sprite_linebuf_pp dut (
    .clk48m(clk48m), .nRESET(nRESET), .pix_ce(pix_ce), .line_start(line_start),
    .flip(flip), .wr_load(wr_load), .wr_x(wr_x), .wr_valid(wr_valid),
    .wr_pix(wr_pix), .wr_ready(wr_ready), .rd_pix(rd_pix), .bank_sel(bank_sel)
  );

  always #5 clk48m = ~clk48m;

  task automatic tick();
    @(negedge clk48m);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic swap();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  // One pixel per two clocks; rd_pix sampled one and two clocks after each pix_ce.
  task automatic scan();
    for (int i = 0; i < LINE_LEN; i++) begin
      pix_ce = 1'b1;
      tick();
      pix_ce = 1'b0;
      mid_d[i] = rd_pix;
      tick();
      line_d[i] = rd_pix;
    end
  endtask

  task automatic put(input logic ld, input logic [7:0] x, input logic [7:0] p);
    logic acc;
    logic done;
    done     = 1'b0;
    wr_valid = 1'b1;
    wr_load  = ld;
    wr_x     = x;
    wr_pix   = p;
    for (int i = 0; i < 8 && !done; i++) begin
      acc = wr_ready;
      tick();
      if (acc) done = 1'b1;
    end
    wr_valid = 1'b0;
    wr_load  = 1'b0;
    chk("put_accepted", 32'(done), 32'd1);
  endtask

  task automatic clr_exp();
    for (int i = 0; i < LINE_LEN; i++) exp_l[i] = 8'h00;
  endtask

  task automatic chk_line(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < LINE_LEN; i++) if (line_d[i] !== exp_l[i]) n++;
    chk(tag, 32'(n), 32'd0);
  endtask

  initial begin
    nRESET = 1'b0; pix_ce = 1'b0; line_start = 1'b0; flip = 1'b0;
    wr_load = 1'b0; wr_valid = 1'b0; wr_x = 8'h00; wr_pix = 8'h00;
    tick(); tick();
    nRESET = 1'b1;
    tick();
    swap();
    for (int i = 0; i < 5; i++) begin
      pix_ce = 1'b1; tick(); pix_ce = 1'b0; tick();
    end
    // Mid-line reset: everything returns to its idle values.
    nRESET = 1'b0;
    #1;
    chk("rst_bank_sel", 32'(bank_sel), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_rd_pix", 32'(rd_pix), 32'd0);
    tick();
    nRESET = 1'b1;
    tick();

    // Line A: unarmed, rd_pix must stay 0 while bank 0 is cleared.
    swap();
    chk("swap1_bank", 32'(bank_sel), 32'd1);
    scan();
    clr_exp();
    chk_line("unarmed_zero");

    // Line B: write test-2 pixels into bank 0.
    swap();
    chk("swap2_bank", 32'(bank_sel), 32'd0);
    chk("swap2_ready", 32'(wr_ready), 32'd1);
    put(1'b1, 8'h10, 8'h21);
    put(1'b0, 8'h00, 8'h00);
    put(1'b0, 8'h00, 8'h33);
    scan();

    // Line C: read bank 0; write wrap pixels into bank 1.
    swap();
    chk("swap3_bank", 32'(bank_sel), 32'd1);
    put(1'b1, 8'h00, 8'h5A);
    put(1'b0, 8'h00, 8'h6B);
    put(1'b0, 8'h00, 8'h7C);
    scan();
    clr_exp();
    exp_l[8'h0F] = 8'h21;
    exp_l[8'h11] = 8'h33;
    chk("t2_x0f", 32'(line_d[8'h0F]), 32'h21);
    chk("t2_x10_skip", 32'(line_d[8'h10]), 32'h00);
    chk("t2_x11", 32'(line_d[8'h11]), 32'h33);
    chk_line("t2_line");

    // Line D: wrap pixels at 0xFF, 0x00, 0x01.
    swap();
    scan();
    clr_exp();
    exp_l[8'hFF] = 8'h5A;
    exp_l[8'h00] = 8'h6B;
    exp_l[8'h01] = 8'h7C;
    chk("t4_xff", 32'(line_d[8'hFF]), 32'h5A);
    chk("t4_x00", 32'(line_d[8'h00]), 32'h6B);
    chk("t4_x01", 32'(line_d[8'h01]), 32'h7C);
    chk_line("t4_line");

    // Line E: bank 0 was scanned already, so it must read back empty.
    swap();
    put(1'b1, 8'h03, 8'h45);
    scan();
    clr_exp();
    chk_line("t3_cleared");

    // Line F: flipped scan; x=0x02 appears at scan index 0xFD.
    flip = 1'b1;
    swap();
    flip = 1'b0;
    put(1'b1, 8'h01, 8'h99);
    scan();
    chk("t5_mid_old", 32'(mid_d[8'hFD]), 32'h00);
    chk("t5_flip_pix", 32'(line_d[8'hFD]), 32'h45);
    chk("t5_hold", 32'(mid_d[8'hFE]), 32'h45);
    clr_exp();
    exp_l[8'hFD] = 8'h45;
    chk_line("t5_line");

    // Line G: line_start with pix_ce reads RD_START from the new read bank.
    line_start = 1'b1;
    pix_ce     = 1'b1;
    tick();
    line_start = 1'b0;
    pix_ce     = 1'b0;
    tick();
    chk("ls_ce_read", 32'(rd_pix), 32'h99);
    chk("ls_ce_bank", 32'(bank_sel), 32'd1);
    tick(); tick();
    chk("rd_pix_held", 32'(rd_pix), 32'h99);

`ifdef SPRITE_LINEBUF_PRIO_EN
    put(1'b1, 8'h31, 8'h41);
    chk("prio_ready_rd", 32'(wr_ready), 32'd0);
    tick();
    chk("prio_ready_ck", 32'(wr_ready), 32'd0);
    tick();
    chk("prio_ready_idle", 32'(wr_ready), 32'd1);
    put(1'b1, 8'h31, 8'h52);
    put(1'b1, 8'h41, 8'h63);
    // Swap while the last pixel sits in W_RD.
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    chk("prio_swap_bank", 32'(bank_sel), 32'd0);
    scan();
    clr_exp();
    exp_l[8'h30] = 8'h41;
    exp_l[8'h40] = 8'h63;
    chk("prio_first_wins", 32'(line_d[8'h30]), 32'h41);
    chk("prio_old_bank", 32'(line_d[8'h40]), 32'h63);
    chk_line("prio_line");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
